// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared selection helpers for arbitrated multiplexers
// Contents:
//   SEL_MAX_W  widest selection index any arbitrated mux in the core uses
//   sel_t      generic selection index; users cast to their own SEL_W
//   next_ptr   round-robin successor of a grant, wrapping at n-1 -> 0
package mux_pkg;

    localparam int SEL_MAX_W = 8;

    typedef logic [SEL_MAX_W-1:0] sel_t;

    // Works for any n, not only powers of two, so the wrap is explicit
    // rather than relying on index overflow.
    function automatic sel_t next_ptr(input sel_t g, input int unsigned n);
        return (g == sel_t'(n - 1)) ? '0 : sel_t'(g + 1'b1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant search
// Ports:
//   req        one request bit per channel
//   ptr        channel with highest priority this cycle (0..NUM_VECTORS-1)
//   grant      first requesting channel at or above ptr, with wrap-around
//   any_grant  at least one request is set; grant is 0 when this is low
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_VECTORS = 4,
    localparam int SEL_W       = $clog2(NUM_VECTORS)
) (
    input  logic [NUM_VECTORS-1:0] req,
    input  logic [SEL_W-1:0]       ptr,
    output logic [SEL_W-1:0]       grant,
    output logic                   any_grant
);

    // One extra bit so ptr + k (at most 2N-2) cannot overflow before the wrap.
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] cand;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_VECTORS; k++) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(NUM_VECTORS)) begin
                sum = sum - (SEL_W+1)'(NUM_VECTORS);
            end
            cand = sum[SEL_W-1:0];
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                grant     = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_vector.sv
// rtl/rr_mux_vector.sv - registered round-robin N-way vector mux with valid/ready
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   in_data     packed channels, channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   in_valid    per-channel offer
//   in_ready    one-hot or zero; the granted channel's word is taken
//   out_data    registered selected word
//   out_valid   out_data/out_sel hold a word
//   out_ready   consumer accepts the output word
//   out_sel     channel index that supplied out_data
module rr_mux_vector
    import mux_pkg::*;
#(
    parameter  int BIT_WIDTH   = 32,
    parameter  int NUM_VECTORS = 4,
    localparam int SEL_W       = $clog2(NUM_VECTORS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_VECTORS*BIT_WIDTH-1:0] in_data,
    input  logic [NUM_VECTORS-1:0]           in_valid,
    output logic [NUM_VECTORS-1:0]           in_ready,
    output logic [BIT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SEL_W-1:0]                 out_sel
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             any_grant;
    logic             load_en;
    logic             take;

    rr_arbiter #(
        .NUM_VECTORS (NUM_VECTORS)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Loading while draining keeps full throughput with a single register.
    assign load_en  = !out_valid || out_ready;
    assign take     = load_en && any_grant;
    assign in_ready = take ? (NUM_VECTORS'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            if (any_grant) begin
                out_data  <= in_data[int'(grant)*BIT_WIDTH +: BIT_WIDTH];
                out_sel   <= grant;
                out_valid <= 1'b1;
                ptr       <= SEL_W'(next_ptr(sel_t'(grant), unsigned'(NUM_VECTORS)));
            end else begin
                // Drained with nothing to refill: data and sel keep their last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux_vector.md
# rr_mux_vector

Registered, round-robin arbitrated N-way vector multiplexer with valid/ready handshakes on every input channel and on the output. It generalises the combinational vector mux: selection is no longer externally driven but produced by a fair arbiter, and the result is held in one output register so producers and consumer decouple. It sits in front of shared single-port resources in the out-of-order core, such as the common data bus, the writeback port and the issue port shared by reservation stations.

## Interface
- BIT_WIDTH, 32, width of each data vector.
- NUM_VECTORS, 4, number of input channels, minimum 2, any integer (not restricted to a power of 2).
- SEL_W, $clog2(NUM_VECTORS), derived local parameter, never overridden.
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_VECTORS*BIT_WIDTH  packed {V[N-1], …, V1, V0}; channel i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- in_valid  input  NUM_VECTORS  channel i has a word to offer.
- in_ready  output  NUM_VECTORS  one-hot or zero; channel i's word is taken this cycle.
- out_data  output  BIT_WIDTH  the registered, selected word.
- out_valid  output  1  out_data and out_sel are valid.
- out_ready  input  1  the consumer accepts the output word this cycle.
- out_sel  output  SEL_W  index of the channel that supplied out_data.

## Operation
- Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. Output transfer: out_valid & out_ready.
- load_en = !out_valid | out_ready. The register accepts a new word when it is empty or is being drained in the same cycle.
- Arbiter: search in_valid starting at index ptr and move upward with wrap-around (N-1 → 0). The first set bit is the grant g.
- in_ready[i] = load_en & any(in_valid) & (i == g). At most one bit is set. in_ready is 0 for channels that are not valid.
- On input transfer: out_data ← in_data[g]; out_sel ← g; out_valid ← 1; ptr ← (g == N-1) ? 0 : g+1.
- load_en with no in_valid: out_valid ← 0 (only reachable when draining). out_data and out_sel keep their values. ptr is unchanged.
- Stall (out_valid & !out_ready): out_data, out_sel and ptr hold. All in_ready are 0.
- Producers must hold in_valid and data stable until accepted. The block never drops or duplicates a word.
- Fairness: a channel that stays valid is granted within NUM_VECTORS output transfers.
- Reset: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0. Asserting reset mid-operation discards any held word immediately, without waiting for a clock edge.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready stays high. No bubble occurs on the drain-and-refill cycle.
- in_ready is combinational from in_valid, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- out_valid, out_data and out_sel come directly from flops.
- First grant after reset goes to the lowest valid index at or above 0.

## Structure
- Shared package mux_pkg holds a sel_t typedef helper and a next_ptr wrap function, which other arbitrated muxes in the core reuse.
- Sub-module rr_arbiter (parameter NUM_VECTORS) is purely combinational.
  - Inputs: req, ptr.
  - Outputs: grant index, any_grant.
- The output register and ptr live in rr_mux_vector.

## Test plan
- Reset, then NUM_VECTORS=4, BIT_WIDTH=8, all valid with V0..V3 = 1,10,20,30, out_ready=1 → out_data sequence 1,10,20,30,1 on consecutive cycles; out_sel 0,1,2,3,0.
- Only channel 2 valid (20), out_ready=1 → in_ready=4'b0100 every cycle; out_data=20, out_sel=2 each cycle; ptr stays 3 after each grant.
- out_ready=0 for 5 cycles holding word 10 (sel 1) → out_valid, out_data and out_sel are stable; in_ready=0. Release → next grant is channel 2.
- NUM_VECTORS=3 (non-power-of-2), all valid → grants 0,1,2,0; out_sel never 3.
- rst_n low for 1 ns mid-stream while out_valid=1 → out_valid=0 and out_data=0 immediately. After release, the first grant is to channel 0.
- Random valid/ready over 10k cycles with a scoreboard → no lost or duplicated words; per-channel order is preserved; the wait per continuously-valid channel is at most NUM_VECTORS output transfers.
